// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer (optional subtract via SERIAL_ADDER_SUB_EN)
module serial_adder_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             c_q, c_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic [WIDTH-1:0] load_b;
   logic             load_c;
   logic             load;

`ifdef SERIAL_ADDER_SUB_EN
   // Subtract as A + ~B + 1: invert B on load and seed the carry flop with 1.
   assign load_b = sub ? ~op_b : op_b;
   assign load_c = sub;
`else
   assign load_b = op_b;
   assign load_c = 1'b0;
`endif

   logic ha0_s, ha0_c, ha1_s, ha1_c, c_next;
   assign ha0_s  = a_q[0] ^ b_q[0];
   assign ha0_c  = a_q[0] & b_q[0];
   assign ha1_s  = ha0_s ^ c_q;
   assign ha1_c  = ha0_s & c_q;
   assign c_next = ha0_c | ha1_c;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      load    = 1'b0;

      case (state_q)
         S_IDLE: begin
            load = start;
         end
         S_SHIFT: begin
            r_d   = {ha1_s, r_q[WIDTH-1:1]};
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = c_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               sum_d   = {ha1_s, r_q[WIDTH-1:1]};
               cout_d  = c_next;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // The DONE->IDLE edge doubles as the earliest acceptance edge, giving WIDTH+1 throughput.
            state_d = S_IDLE;
            load    = start;
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         a_d     = op_a;
         b_d     = load_b;
         c_d     = load_c;
         r_d     = '0;
         cnt_d   = '0;
         state_d = S_SHIFT;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign sum       = sum_q;
   assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl
module tb_serial_adder_ctrl;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] op_a, op_b;
   logic             busy, done, carry_out;
   logic [WIDTH-1:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
`ifdef SERIAL_ADDER_SUB_EN
      .sub       (sub),
`endif
      .op_a      (op_a),
      .op_b      (op_b),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out)
   );

   always #5 clk = ~clk;

   int               n_checks = 0;
   int               n_pass   = 0;
   int               n_pushed = 0;
   int               n_done   = 0;
   logic [WIDTH:0]   exp_q[$];
   logic [WIDTH-1:0] prev_sum = '0;
   logic             prev_c   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every done pulse pops one expected result.
   always @(negedge clk) begin
      if (rst_n && done) begin
         n_done++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [WIDTH:0] e;
            e = exp_q.pop_front();
            check("sum", 32'(sum), 32'(e[WIDTH-1:0]));
            check("carry_out", 32'(carry_out), 32'(e[WIDTH]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] es, input logic ec, input int inject_at);
      int busy_cnt;
      int done_n;
      bit hold_ok;
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      exp_q.push_back({ec, es});
      n_pushed++;
      step();
      start    = 1'b0;
      busy_cnt = 0;
      done_n   = -1;
      hold_ok  = 1'b1;
      for (int n = 0; n < 30; n++) begin
         if (n > 0) step();
         if (n == inject_at) begin
            start = 1'b1;
            op_a  = 8'h01;
            op_b  = 8'h01;
         end else if (n == inject_at + 1) begin
            start = 1'b0;
         end
         if (!busy) break;
         busy_cnt++;
         if (done && done_n < 0) done_n = n;
         if (done_n < 0 && (sum !== prev_sum || carry_out !== prev_c)) hold_ok = 1'b0;
      end
      check("latency", 32'(done_n), 32'd8);
      check("busy_cycles", 32'(busy_cnt), 32'd9);
      check("hold_prev", 32'(hold_ok), 32'd1);
      prev_sum = es;
      prev_c   = ec;
   endtask

   initial begin
      int d[3];
      int nd;
      rst_n = 1'b0;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
`ifdef SERIAL_ADDER_SUB_EN
      sub   = 1'b0;
`endif
      repeat (3) step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(carry_out), 32'd0);
      rst_n = 1'b1;
      step();

      run_op(8'h00, 8'h00, 8'h00, 1'b0, -1);
      run_op(8'hFF, 8'h01, 8'h00, 1'b1, -1);
      run_op(8'hA5, 8'h5A, 8'hFF, 1'b0, 3);
      run_op(8'hFF, 8'hFF, 8'hFE, 1'b1, -1);
      run_op(8'h3C, 8'h0F, 8'h4B, 1'b0, -1);

      // start held high: three back-to-back operations
      op_a  = 8'h80;
      op_b  = 8'h80;
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({1'b1, 8'h00});
         n_pushed++;
      end
      nd = 0;
      for (int n = 0; n < 40 && nd < 3; n++) begin
         step();
         if (done) begin
            d[nd] = n;
            nd++;
            if (nd == 3) start = 1'b0;
         end
      end
      check("held_ops", 32'(nd), 32'd3);
      if (nd == 3) begin
         check("held_first", 32'(d[0]), 32'd8);
         check("held_gap1", 32'(d[1] - d[0]), 32'd9);
         check("held_gap2", 32'(d[2] - d[1]), 32'd9);
      end
      for (int n = 0; n < 20 && busy; n++) step();
      check("held_idle", 32'(busy), 32'd0);
      prev_sum = 8'h00;
      prev_c   = 1'b1;

      // reset three edges after the start edge aborts the op
      op_a  = 8'h12;
      op_b  = 8'h34;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      step();
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_sum", 32'(sum), 32'd0);
      check("abort_cout", 32'(carry_out), 32'd0);
      rst_n = 1'b1;
      repeat (12) step();
      prev_sum = 8'h00;
      prev_c   = 1'b0;
      run_op(8'h12, 8'h34, 8'h46, 1'b0, -1);

`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'b1;
      run_op(8'h10, 8'h01, 8'h0F, 1'b1, -1);
      run_op(8'h01, 8'h02, 8'hFF, 1'b0, -1);
      sub = 1'b0;
`endif

      repeat (4) step();
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      check("done_count", 32'(n_done), 32'(n_pushed));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
